// File: rtl/seq_serializer_if.sv
// Word-in / bit-out bundle between a word producer, the serializer and the
// downstream sequence detector. WIDTH must match the serializer's WIDTH.
interface seq_serializer_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             seq_out;
  logic             seq_valid;
  logic             busy;
  logic             word_done;

  // Producer / observer side: drives words in, watches the serial stream.
  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  seq_out,
    input  seq_valid,
    input  busy,
    input  word_done
  );

  // Serializer side.
  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output seq_out,
    output seq_valid,
    output busy,
    output word_done
  );

endinterface

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end for the sequence detector. Words enter a
// one-word holding buffer over valid/ready, move into a shift register and
// leave one bit per enabled clock. A word waiting in the holding buffer is
// reloaded on the last-bit clock, so back-to-back words stream without a gap.
module seq_serializer #(
  parameter int unsigned WIDTH     = 8,     // 2..32
  parameter bit          MSB_FIRST = 1'b1,  // 1: bit WIDTH-1 leaves first
  parameter bit          IDLE_BIT  = 1'b0   // fill value when no word is sent
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  seq_serializer_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_seq_out;
  logic             r_seq_valid;
  logic             r_word_done;

  logic             w_accept;     // word taken into the holding buffer
  logic             w_load;       // holding buffer moves into shreg
  logic             w_shift;      // one bit leaves shreg this clock
  logic             w_last;       // the bit leaving is the word's last
  logic             w_head;       // bit at the outgoing end of shreg
  logic [WIDTH-1:0] w_shreg_adv;  // shreg after moving one bit out

  // The accept decision depends only on registered state, so din_ready
  // never combinationally follows a drain in the same cycle.
  assign w_accept = bus.din_valid && !r_hold_full && !clr;

  // Select the outgoing end of the shift register by bit order.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_head      = r_shreg[WIDTH-1];
      assign w_shreg_adv = {r_shreg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_head      = r_shreg[0];
      assign w_shreg_adv = {1'b0, r_shreg[WIDTH-1:1]};
    end
  endgenerate

  // State register.
  // NOTE: clocked blocks use <= so every register samples pre-edge values,
  // independent of the order the blocks are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-clock datapath controls; clr overrides everything.
  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_last      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Transfer ignores en and emits no data bit this clock.
        if (r_hold_full) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (en) begin
          w_shift = 1'b1;
          if (r_bit_cnt == CNT_W'(1)) begin
            w_last = 1'b1;
            if (r_hold_full) begin
              w_load = 1'b1;          // chain the next word, zero gap
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (clr) begin
      w_state_nxt = ST_IDLE;
      w_load      = 1'b0;
      w_shift     = 1'b0;
      w_last      = 1'b0;
    end
  end

  // Holding-buffer payload; only meaningful while r_hold_full is set.
  // NOTE: pure data storage qualified by a valid flag needs no reset; only
  // the flag is reset, which keeps the data flops cheap.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_hold <= bus.din;
    end
  end

  // Holding-buffer occupancy, shift register, bit counter and serial outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_full <= 1'b0;
      r_shreg     <= '0;
      r_bit_cnt   <= '0;
      r_seq_out   <= IDLE_BIT;
      r_seq_valid <= 1'b0;
      r_word_done <= 1'b0;
    end else if (clr) begin
      r_hold_full <= 1'b0;
      r_shreg     <= '0;
      r_bit_cnt   <= '0;
      r_seq_out   <= IDLE_BIT;
      r_seq_valid <= 1'b0;
      r_word_done <= 1'b0;
    end else begin
      r_word_done <= w_last;

      if (w_load) begin
        r_hold_full <= 1'b0;
      end else if (w_accept) begin
        r_hold_full <= 1'b1;
      end

      if (w_shift) begin
        r_seq_out   <= w_head;
        r_seq_valid <= 1'b1;
        r_shreg     <= w_shreg_adv;
        r_bit_cnt   <= r_bit_cnt - CNT_W'(1);
      end else if ((r_state == ST_IDLE) && en) begin
        r_seq_out   <= IDLE_BIT;
        r_seq_valid <= 1'b0;
      end

      // A load replaces the word just emptied (or the empty idle register).
      if (w_load) begin
        r_shreg   <= r_hold;
        r_bit_cnt <= CNT_W'(WIDTH);
      end
    end
  end

  assign bus.din_ready = !r_hold_full;
  assign bus.seq_out   = r_seq_out;
  assign bus.seq_valid = r_seq_valid;
  assign bus.word_done = r_word_done;
  assign bus.busy      = r_hold_full || (r_state == ST_SHIFT);

endmodule
